spi_master_ctrl: RTL and testbench

SPI initiator that drives the register-transfer protocol consumed by the SPI responder control unit. On a start pulse it asserts chip select, shifts `NUM_BYTES` bytes out MSB-first on `mosi` while capturing `miso`, and inserts an inter-byte gap so the responder can write its register, increment its register number and reload its shift register. Each byte is fetched from a local register file by index, and each received byte is handed back with its index. The block sits between the host-side register file and the SPI pins.

---
 rtl/spi_master_ctrl.sv | 99 +++++++++
 tb/tb_spi_master_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 initiator that streams NUM_BYTES register bytes per transaction,
// with an inter-byte gap so the responder can commit each register.
module spi_master_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int BYTE_GAP  = 8,
    parameter int NUM_BYTES = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] txData,
    output logic [6:0] txRegNum,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       chipSelect,
    output logic [7:0] rxData,
    output logic       rxWrite,
    output logic [6:0] rxRegNum,
    output logic       busy,
    output logic       done
);
    localparam int MAX_PHASE = CLK_DIV > BYTE_GAP ? CLK_DIV : BYTE_GAP;
    localparam int PW = MAX_PHASE > 1 ? $clog2(MAX_PHASE) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(BYTE_GAP - 1);
    localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, BYTE_DONE, GAP, HOLD} stateT;

    stateT state, nextState;
    logic [PW-1:0] phase, phaseLoad;
    logic phaseEnd, loadByte;
    logic [2:0] bitCnt;
    logic [6:0] byteIdx;
    logic [7:0] shifter;

    // done blocks start for one cycle so a request in the done cycle is ignored
    always_comb begin
        phaseEnd = phase == '0;
        nextState = state;
        unique case (state)
            IDLE:      if (start && !done) nextState = LOW;
            LOW:       if (phaseEnd) nextState = HIGH;
            HIGH:      if (phaseEnd) nextState = bitCnt == 3'd7 ? BYTE_DONE : LOW;
            BYTE_DONE: nextState = byteIdx == LAST_IDX ? HOLD : GAP;
            GAP:       if (phaseEnd) nextState = LOW;
            HOLD:      if (phaseEnd) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
        phaseLoad = nextState == GAP ? GAP_LAST : DIV_LAST;
        loadByte = nextState == LOW && (state == IDLE || state == GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            bitCnt     <= '0;
            byteIdx    <= '0;
            shifter    <= '0;
            mosi       <= 1'b0;
            sclk       <= 1'b0;
            chipSelect <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rxWrite    <= 1'b0;
            rxData     <= '0;
            rxRegNum   <= '0;
        end else begin
            state      <= nextState;
            phase      <= nextState != state ? phaseLoad : phaseEnd ? phase : phase - 1'b1;
            sclk       <= nextState == HIGH;
            chipSelect <= nextState == IDLE;
            busy       <= nextState != IDLE;
            done       <= state == HOLD && nextState == IDLE;
            rxWrite    <= state == BYTE_DONE;
            // mosi only moves on the falling side so it is stable for a full low phase
            if (loadByte) begin
                shifter <= txData;
                mosi    <= txData[7];
                bitCnt  <= '0;
            end else if (state == LOW && nextState == HIGH) begin
                shifter <= {shifter[6:0], miso};
            end else if (state == HIGH && phaseEnd) begin
                bitCnt <= bitCnt + 1'b1;
                if (nextState == LOW) mosi <= shifter[7];
            end
            if (state == BYTE_DONE) begin
                rxData   <= shifter;
                rxRegNum <= byteIdx;
            end
            if (state == BYTE_DONE && nextState == GAP) byteIdx <= byteIdx + 1'b1;
            else if (nextState == IDLE) byteIdx <= '0;
        end
    end

    assign txRegNum = byteIdx;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of spi_master_ctrl in a 3-byte loopback config and a
// single-byte CLK_DIV=1 config.
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start0 = 1'b0, start1 = 1'b0, tie1 = 1'b0;
    logic [7:0] mem0 [4];
    logic [7:0] mem1;
    logic [7:0] txData0, txData1, rxData0, rxData1;
    logic [6:0] txRegNum0, txRegNum1, rxRegNum0, rxRegNum1;
    logic sclk0, mosi0, cs0, rxWrite0, busy0, done0, miso0;
    logic sclk1, mosi1, cs1, rxWrite1, busy1, done1, miso1;

    assign txData0 = mem0[txRegNum0[1:0]];
    assign txData1 = mem1;
    assign miso0 = tie1 ? 1'b1 : mosi0;
    assign miso1 = mosi1;

    spi_master_ctrl #(.CLK_DIV(2), .BYTE_GAP(3), .NUM_BYTES(3)) u0 (
        .clk(clk), .rst(rst), .start(start0), .txData(txData0), .txRegNum(txRegNum0),
        .miso(miso0), .sclk(sclk0), .mosi(mosi0), .chipSelect(cs0), .rxData(rxData0),
        .rxWrite(rxWrite0), .rxRegNum(rxRegNum0), .busy(busy0), .done(done0));

    spi_master_ctrl #(.CLK_DIV(1), .BYTE_GAP(2), .NUM_BYTES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .txData(txData1), .txRegNum(txRegNum1),
        .miso(miso1), .sclk(sclk1), .mosi(mosi1), .chipSelect(cs1), .rxData(rxData1),
        .rxWrite(rxWrite1), .rxRegNum(rxRegNum1), .busy(busy1), .done(done1));

    int nChecks = 0, nPass = 0;
    int csLow, rxN, rises, unstable, mosiOnes;
    bit seenDone;
    logic [7:0] mosiBits;
    logic [6:0] rxIdx [8];
    logic [7:0] rxVal [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setStart(input bit sel, input bit v);
        if (sel) start1 = v;
        else start0 = v;
    endtask

    // Pulse start, then sample once per cycle until done (bounded), logging the transfer.
    task automatic runTxn(input bit sel, input int restartAt, input bit startInDone);
        int cyc = 0;
        logic pS = 1'b0, pM, s, m;
        csLow = 0; rxN = 0; rises = 0; unstable = 0; mosiOnes = 0; mosiBits = '0; seenDone = 0;
        pM = sel ? mosi1 : mosi0;
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
        while (!seenDone && cyc < 3000) begin
            s = sel ? sclk1 : sclk0;
            m = sel ? mosi1 : mosi0;
            if (!(sel ? cs1 : cs0)) csLow++;
            if (m) mosiOnes++;
            if ((sel ? rxWrite1 : rxWrite0) && rxN < 8) begin
                rxIdx[rxN] = sel ? rxRegNum1 : rxRegNum0;
                rxVal[rxN] = sel ? rxData1 : rxData0;
                rxN++;
            end
            if (s && !pS) begin
                rises++;
                if (m !== pM) unstable++;
                mosiBits = {mosiBits[6:0], m};
            end
            pS = s;
            pM = m;
            if (sel ? done1 : done0) seenDone = 1;
            else begin
                setStart(sel, cyc == restartAt);
                @(negedge clk);
                cyc++;
            end
        end
        setStart(sel, 1'b0);
        check("done seen", seenDone, 1);
        if (startInDone) begin
            setStart(sel, 1'b1);
            @(negedge clk);
            setStart(sel, 1'b0);
            check("start in done cycle busy", sel ? busy1 : busy0, 0);
            check("start in done cycle cs", sel ? cs1 : cs0, 1);
        end
    endtask

    initial begin
        int evt;
        mem0[0] = 8'hA5; mem0[1] = 8'h3C; mem0[2] = 8'hFF; mem0[3] = 8'h00;
        mem1 = 8'h80;
        idle(3);
        check("reset cs", cs0, 1);
        check("reset sclk", sclk0, 0);
        check("reset mosi", mosi0, 0);
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        check("reset rxWrite", rxWrite0, 0);
        check("reset rxData", rxData0, 0);
        check("reset rxRegNum", rxRegNum0, 0);
        check("reset txRegNum", txRegNum0, 0);
        rst = 1'b0;
        idle(2);

        runTxn(0, -1, 0);
        check("loopback cs low cycles", csLow, 107);
        check("loopback rx count", rxN, 3);
        check("loopback idx0", rxIdx[0], 0);
        check("loopback val0", rxVal[0], 8'hA5);
        check("loopback idx1", rxIdx[1], 1);
        check("loopback val1", rxVal[1], 8'h3C);
        check("loopback idx2", rxIdx[2], 2);
        check("loopback val2", rxVal[2], 8'hFF);
        check("loopback sclk rises", rises, 24);
        check("loopback mosi stable", unstable, 0);
        check("loopback last byte bits", mosiBits, 8'hFF);
        check("done cycle busy", busy0, 0);
        check("done cycle txRegNum", txRegNum0, 0);
        idle(2);

        runTxn(1, -1, 0);
        check("div1 cs low cycles", csLow, 18);
        check("div1 sclk rises", rises, 8);
        check("div1 mosi stable", unstable, 0);
        check("div1 mosi bits", mosiBits, 8'h80);
        check("div1 rx count", rxN, 1);
        check("div1 rx val", rxVal[0], 8'h80);
        check("div1 rx idx", rxIdx[0], 0);
        check("div1 txRegNum", txRegNum1, 0);
        idle(2);

        tie1 = 1'b1;
        mem0[0] = 8'h00; mem0[1] = 8'h00; mem0[2] = 8'h00;
        runTxn(0, -1, 0);
        check("miso1 rx count", rxN, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("miso1 val%0d", i), rxVal[i], 8'hFF);
            check($sformatf("miso1 idx%0d", i), rxIdx[i], i);
        end
        check("miso1 mosi stays low", mosiOnes, 0);
        tie1 = 1'b0;
        idle(2);

        mem0[0] = 8'hA5; mem0[1] = 8'h3C; mem0[2] = 8'hFF;
        runTxn(0, 20, 1);
        check("restart mid-byte cs low", csLow, 107);
        check("restart mid-byte rx count", rxN, 3);
        runTxn(0, -1, 0);
        check("restart after done cs low", csLow, 107);
        check("restart after done idx0", rxIdx[0], 0);
        check("restart after done val0", rxVal[0], 8'hA5);
        idle(2);

        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        idle(52);
        check("midbyte txRegNum", txRegNum0, 1);
        check("midbyte cs", cs0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort cs", cs0, 1);
        check("abort sclk", sclk0, 0);
        check("abort busy", busy0, 0);
        check("abort txRegNum", txRegNum0, 0);
        evt = 0;
        for (int i = 0; i < 60; i++) begin
            if (rxWrite0 || done0) evt++;
            @(negedge clk);
        end
        check("abort no rxWrite/done", evt, 0);
        mem0[0] = 8'h12; mem0[1] = 8'h34; mem0[2] = 8'h56;
        runTxn(0, -1, 0);
        check("post-abort cs low", csLow, 107);
        check("post-abort idx0", rxIdx[0], 0);
        check("post-abort val0", rxVal[0], 8'h12);
        check("post-abort val1", rxVal[1], 8'h34);
        check("post-abort val2", rxVal[2], 8'h56);
        idle(2);

        rst = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b0;
        check("rst+start busy", busy0, 0);
        check("rst+start cs", cs0, 1);
        @(negedge clk);
        check("rst+start still idle", busy0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
